// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Decoupling FIFO between instruction fetch and decode. It holds up to DEPTH
//   {pc, inst} pairs from instruction memory and shows the oldest pair to
//   decode. A control-flow redirect (flush) discards every buffered pair.
//
// Parameters
//   DEPTH   number of entries (power of two, >= 2)
//   PC_W    pc width
//   INST_W  instruction word width
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   flush      discard all entries (redirect)
//   in_valid   fetch offers a pair this cycle
//   in_ready   queue can accept a pair (registered state only)
//   in_pc      pc of the offered instruction
//   in_inst    offered instruction word
//   out_valid  oldest pair is available to decode
//   out_ready  decode consumes the oldest pair this cycle
//   out_pc     pc of the oldest entry, 0 when empty
//   out_inst   oldest instruction word, 0 when empty
//   count      current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INST_W-1:0]          in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [INST_W-1:0]          out_inst,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [INST_W-1:0] mem_inst [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  occ;

    logic push;
    logic pop;

    // Both handshakes depend only on registered occupancy, so there is no
    // combinational path from out_ready to in_ready: a full queue refuses a
    // push even while it is being popped.
    assign in_ready  = (occ != CNT_FULL);
    assign out_valid = (occ != '0);

    assign push = in_valid  & in_ready;
    assign pop  = out_valid & out_ready;

    assign count = occ;

    // Zero the head when empty so decode never sees stale storage.
    assign out_pc   = out_valid ? mem_pc[rd_ptr]   : '0;
    assign out_inst = out_valid ? mem_inst[rd_ptr] : '0;

    // Pointer and occupancy state. rst and flush both restart from slot 0;
    // pointers are a power-of-two width so they wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                occ <= occ + CNT_ONE;
            end else if (pop && !push) begin
                occ <= occ - CNT_ONE;
            end
        end
    end

    // Storage has no reset; a write is suppressed whenever the pointers are
    // being cleared so a pair offered during rst/flush is never retained.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem_pc[wr_ptr]   <= in_pc;
            mem_inst[wr_ptr] <= in_inst;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int PC_W   = 64;
    localparam int INST_W = 32;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic [CNT_W-1:0]  count;

    int tests;
    int fails;

    // Reference model: a plain queue of {pc, inst} pairs.
    logic [PC_W+INST_W-1:0] model_q [$];

    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare every DUT output against the model's view of the queue.
    task automatic check_model();
        int sz;
        logic [PC_W-1:0]   exp_pc;
        logic [INST_W-1:0] exp_inst;
        sz = model_q.size();
        exp_pc   = '0;
        exp_inst = '0;
        if (sz != 0) begin
            exp_pc   = model_q[0][PC_W+INST_W-1:INST_W];
            exp_inst = model_q[0][INST_W-1:0];
        end
        chk("model_count",     64'(count),     64'(sz));
        chk("model_out_valid", 64'(out_valid), 64'(sz != 0));
        chk("model_in_ready",  64'(in_ready),  64'(sz != DEPTH));
        chk("model_out_pc",    64'(out_pc),    64'(exp_pc));
        chk("model_out_inst",  64'(out_inst),  64'(exp_inst));
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model from the
    // inputs currently applied, then cross the rising edge.
    task automatic step();
        int  sz;
        bit  do_push;
        bit  do_pop;
        check_model();
        sz      = model_q.size();
        do_push = in_valid && (sz != DEPTH);
        do_pop  = out_ready && (sz != 0);
        if (rst || flush) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({in_pc, in_inst});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; flush = 0; in_valid = 0; out_ready = 0;
        in_pc = '0; in_inst = '0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle_inputs();

        // 1: reset two cycles with in_valid asserted
        rst = 1; in_valid = 1; in_pc = 64'hdead; in_inst = 32'hbeef;
        @(posedge clk); #1;
        model_q.delete();
        step();
        rst = 0; in_valid = 0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_inst",  64'(out_inst),  64'd0);
        chk("rst_out_pc",    64'(out_pc),    64'd0);

        // 2: fill four entries, decode stalled
        for (int i = 0; i < 4; i++) begin
            in_valid = 1;
            in_pc    = 64'h1000 + 64'(4 * i);
            in_inst  = 32'h00000013 | (32'(i) << 7);
            step();
        end
        chk("fill_count",    64'(count),    64'd4);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        chk("fill_out_pc",   64'(out_pc),   64'h1000);
        in_pc = 64'h1010; in_inst = 32'h00000013;
        step();
        chk("fill_5th_count",  64'(count),  64'd4);
        chk("fill_5th_out_pc", 64'(out_pc), 64'h1000);

        // 3: drain in order
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_out_pc", 64'(out_pc), 64'h1000 + 64'(4 * i));
            step();
        end
        chk("drain_empty", 64'(out_valid), 64'd0);
        out_ready = 0;

        // 4: concurrent push/pop at count 2, then wrap the pointers
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_pc = 64'h1f00 + 64'(4 * i); in_inst = 32'h13;
            step();
        end
        chk("conc_pre_count", 64'(count), 64'd2);
        in_pc = 64'h2000; in_inst = 32'h00100013; out_ready = 1;
        step();
        chk("conc_count",  64'(count),  64'd2);
        chk("conc_out_pc", 64'(out_pc), 64'h1f04);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            in_pc = 64'h2004 + 64'(4 * i); in_inst = 32'(i);
            step();
        end
        chk("wrap_count",  64'(count),  64'd2);
        chk("wrap_out_pc", 64'(out_pc), 64'h2000 + 64'(4 * (3 * DEPTH - 1)));
        in_valid = 0; out_ready = 1;
        step(); step();

        // 5: flush with count 3 and a concurrent offer
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_pc = 64'h2800 + 64'(4 * i); in_inst = 32'h13;
            step();
        end
        chk("flush_pre_count", 64'(count), 64'd3);
        flush = 1; in_pc = 64'h3000; out_ready = 1;
        step();
        flush = 0; out_ready = 0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_count",     64'(count),     64'd0);
        in_pc = 64'h4000; in_inst = 32'h00200013;
        step();
        in_valid = 0;
        chk("post_flush_out_pc", 64'(out_pc), 64'h4000);

        // 6: full with pop and offer in the same cycle
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_pc = 64'h5000 + 64'(4 * i); in_inst = 32'h13;
            step();
        end
        chk("fullpop_pre_count", 64'(count), 64'd4);
        in_pc = 64'h6000; out_ready = 1;
        chk("fullpop_in_ready", 64'(in_ready), 64'd0);
        step();
        chk("fullpop_count",  64'(count),  64'd3);
        chk("fullpop_out_pc", 64'(out_pc), 64'h5000);

        // Random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            rst       = ($urandom_range(0, 511) == 0);
            flush     = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_pc     = {32'($urandom), 32'($urandom)};
            in_inst   = 32'($urandom);
            step();
        end
        idle_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
